// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: an iterative shift-add-3 converter with a start/busy/done
// handshake, an auto-retrigger on operand change, and registered active-low seven-segment outputs.
module bcd_display_ctrl #(
  parameter int unsigned BIN_W = 6,
  parameter int unsigned NDIG  = 2
) (
  input  logic                fr_CLOCK_50,
  input  logic                fr_RESET,
  input  logic [BIN_W-1:0]    fr_SW,
  input  logic                fr_START,
  input  logic                fr_AUTO,
  input  logic                fr_BLANK_LZ,
  output logic                to_BUSY,
  output logic                to_DONE,
  output logic [4*NDIG-1:0]   to_BCD,
  output logic [8*NDIG-1:0]   to_HEX
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MaxBin = (64'd1 << BIN_W) - 64'd1;
  localparam logic [63:0] MaxDec = pow10(NDIG) - 64'd1;

  generate
    if (MaxBin > MaxDec) begin : g_bad_params
      $error("bcd_display_ctrl: NDIG too small to hold the largest BIN_W-bit operand");
    end
  endgenerate

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned AccW = 4 * NDIG;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Walk from the top digit down; blanking stops at the first non-zero digit and never hits digit 0.
  function automatic logic [8*NDIG-1:0] encode(input logic [AccW-1:0] bcd, input logic blank_lz);
    logic [8*NDIG-1:0] out;
    logic              lead;
    logic [3:0]        d;
    out  = '1;
    lead = blank_lz;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (lead && (i > 0) && (d == 4'd0)) begin
        out[8*i +: 8] = 8'hFF;
      end else begin
        out[8*i +: 8] = seg_code(d);
        lead = 1'b0;
      end
    end
    return out;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [BIN_W-1:0]   sreg_q, sreg_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]   last_val_q, last_val_d;
  logic               last_valid_q, last_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AccW-1:0]    bcd_q, bcd_d;
  logic [8*NDIG-1:0]  hex_q, hex_d;

  logic                  go;
  logic [AccW-1:0]       adj;
  logic [AccW+BIN_W-1:0] shifted;

  assign go = fr_START | (fr_AUTO & (~last_valid_q | (fr_SW != last_val_q)));

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, sreg_q} << 1;
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    last_val_d   = last_val_q;
    last_valid_d = last_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    bcd_d        = bcd_q;
    hex_d        = hex_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          sreg_d     = fr_SW;
          last_val_d = fr_SW;
          acc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        {acc_d, sreg_d} = shifted;
        cnt_d           = cnt_q + CntW'(1);
        // Results load from the post-shift value on the same edge that enters DONE.
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d      = StDone;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          bcd_d        = shifted[AccW+BIN_W-1 -: AccW];
          hex_d        = encode(shifted[AccW+BIN_W-1 -: AccW], fr_BLANK_LZ);
          last_valid_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fr_CLOCK_50) begin
    if (fr_RESET) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      last_val_q   <= '0;
      last_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bcd_q        <= '0;
      hex_q        <= '1;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      last_val_q   <= last_val_d;
      last_valid_q <= last_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bcd_q        <= bcd_d;
      hex_q        <= hex_d;
    end
  end

  assign to_BUSY = busy_q;
  assign to_DONE = done_q;
  assign to_BCD  = bcd_q;
  assign to_HEX  = hex_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: directed scenarios plus randomized conversions
// compared against an arithmetic decimal-digit model.
module tb_bcd_display_ctrl;

  localparam int unsigned BIN_W = 6;
  localparam int unsigned NDIG  = 2;
  localparam int          LAT   = BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BIN_W-1:0]  sw = '0;
  logic              start = 1'b0;
  logic              auto_en = 1'b0;
  logic              blank = 1'b0;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] bcd;
  logic [8*NDIG-1:0] hex;

  int checks = 0;
  int failures = 0;

  bcd_display_ctrl #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .fr_CLOCK_50 (clk),
    .fr_RESET    (rst),
    .fr_SW       (sw),
    .fr_START    (start),
    .fr_AUTO     (auto_en),
    .fr_BLANK_LZ (blank),
    .to_BUSY     (busy),
    .to_DONE     (done),
    .to_BCD      (bcd),
    .to_HEX      (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [4*NDIG-1:0] model_bcd(input int v);
    logic [4*NDIG-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digits at or beyond the number's printed decimal length are blank (length is at least 1).
  function automatic logic [8*NDIG-1:0] model_hex(input int v, input bit blk);
    logic [8*NDIG-1:0] r;
    int len;
    int t;
    len = 1;
    t = v / 10;
    while (t > 0) begin
      len++;
      t = t / 10;
    end
    t = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[8*i +: 8] = (blk && i >= len) ? 8'hFF : seg_of(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_hex", 64'(hex), 64'hFFFF);
    rst = 1'b0;
  endtask

  // Full conversion with cycle-exact handshake checks; returns in the first IDLE cycle.
  task automatic convert(input int v, input bit blk);
    sw = BIN_W'(v);
    blank = blk;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= BIN_W; c++) begin
      check("busy_shift", 64'(busy), 64'd1);
      check("done_early", 64'(done), 64'd0);
      tick();
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("bcd", 64'(bcd), 64'(model_bcd(v)));
    check("hex", 64'(hex), 64'(model_hex(v, blk)));
    tick();
    check("done_clear", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  initial begin
    bit ok;
    int n;
    int v;

    do_reset();

    // T1
    convert(63, 1'b0);
    check("t1_bcd", 64'(bcd), 64'h63);
    check("t1_hex", 64'(hex), 64'h82B0);

    // T2
    convert(5, 1'b1);
    check("t2_hex5", 64'(hex), 64'hFF92);
    convert(0, 1'b1);
    check("t2_hex0", 64'(hex), 64'hFFC0);
    convert(7, 1'b0);
    check("t2_noblank", 64'(hex), 64'hC0F8);

    // T3: operand and start changes mid-conversion are ignored
    sw = 6'd42;
    blank = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    sw = 6'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 4; c <= LAT; c++) begin
      if (c == LAT) check("t3_done", 64'(done), 64'd1);
      else if (done) n++;
      if (c < LAT) tick();
    end
    check("t3_bcd", 64'(bcd), 64'h42);
    count_done(20, v);
    check("t3_single_done", 64'(n + v), 64'd0);

    // T4: auto retrigger
    do_reset();
    auto_en = 1'b1;
    sw = 6'd9;
    wait_done(20, ok);
    check("t4_auto_start", 64'(ok), 64'd1);
    check("t4_bcd9", 64'(bcd), 64'h09);
    count_done(50, n);
    check("t4_no_retrigger", 64'(n), 64'd0);
    sw = 6'd10;
    wait_done(20, ok);
    check("t4_change_start", 64'(ok), 64'd1);
    check("t4_bcd10", 64'(bcd), 64'h10);
    auto_en = 1'b0;
    tick();
    tick();

    // T5: reset aborts a conversion
    sw = 6'd37;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_bcd", 64'(bcd), 64'd0);
    check("t5_hex", 64'(hex), 64'hFFFF);
    count_done(15, n);
    check("t5_no_done", 64'(n), 64'd0);

    // Held start repeats every BIN_W+2 cycles
    sw = BIN_W'($urandom_range(0, 63));
    start = 1'b1;
    wait_done(20, ok);
    check("held_first", 64'(ok), 64'd1);
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("held_found", 64'(ok), 64'd1);
    check("held_period", 64'(n), 64'(BIN_W + 2));
    start = 1'b0;
    count_done(12, n);

    // T6: full sweep with random blanking
    for (int i = 0; i < 64; i++) convert(i, bit'($urandom_range(0, 1)));

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 63));
      convert(v, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
